// File: rtl/seven_segs_pkg.sv
// seven_segs_pkg: shared segment patterns and helpers
// for the seven-segment display drivers.
package seven_segs_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  localparam seg_t SEGS_OFF = 7'h00;

  function automatic int idx_width(
    input int n
  );
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_segs.sv
// hex_to_segs: combinational nibble to active-high
// {g,f,e,d,c,b,a} pattern.
module hex_to_segs
  import seven_segs_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_segs
);

  always_comb begin
    o_segs = SEGS_OFF;
    unique case (i_nibble)
      4'h0: o_segs = SEG_0;
      4'h1: o_segs = SEG_1;
      4'h2: o_segs = SEG_2;
      4'h3: o_segs = SEG_3;
      4'h4: o_segs = SEG_4;
      4'h5: o_segs = SEG_5;
      4'h6: o_segs = SEG_6;
      4'h7: o_segs = SEG_7;
      4'h8: o_segs = SEG_8;
      4'h9: o_segs = SEG_9;
      4'hA: o_segs = SEG_A;
      4'hB: o_segs = SEG_B;
      4'hC: o_segs = SEG_C;
      4'hD: o_segs = SEG_D;
      4'hE: o_segs = SEG_E;
      4'hF: o_segs = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_segs_scan.sv
// seven_segs_scan: time-multiplexed N-digit driver with
// frame snapshot, dead time, blank and output polarity.
module seven_segs_scan
  import seven_segs_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [4*N_DIGITS-1:0] Digits,
  input  logic [N_DIGITS-1:0]   DpIn,
  input  logic [N_DIGITS-1:0]   DigitEn,
  input  logic                  Blank,
  output logic [6:0]            Segs,
  output logic                  Dp,
  output logic [N_DIGITS-1:0]   An,
  output logic                  ScanTick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = idx_width(N_DIGITS);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_L =
    CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DIGITS - 1);

  localparam seg_t SEG_INV =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_INV =
    (SEG_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_INV =
    (AN_ACTIVE_LOW != 0) ? '1 : '0;

  generate
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n
      $error("seven_segs_scan: N_DIGITS must be 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("seven_segs_scan: REFRESH_DIV must be >= 2");
    end
    if (DEAD_CYCLES < 0 ||
        DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
      $error("seven_segs_scan: bad DEAD_CYCLES");
    end
  endgenerate

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [3:0]          r_snap_dig [N_DIGITS];
  logic [N_DIGITS-1:0] r_snap_dp;
  logic [N_DIGITS-1:0] r_snap_en;
  logic [N_DIGITS-1:0] r_an;
  seg_t                r_segs;
  logic                r_dp;
  logic                r_tick;

  logic                w_slot_end;
  logic                w_idx_last;
  logic                w_frame_end;
  logic                w_live;
  logic                w_lit;
  logic [3:0]          w_nibble;
  seg_t                w_dec;
  logic [N_DIGITS-1:0] w_an;
  seg_t                w_segs;
  logic                w_dp;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_idx_last  = (r_idx == IDX_LAST);
  assign w_frame_end = w_slot_end && w_idx_last;

  // With no dead time every slot cycle is live.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_live = 1'b1;
    end else begin : g_dead
      assign w_live = (r_cnt >= DEAD_L);
    end
  endgenerate

  assign w_lit = w_live && r_snap_en[r_idx] && !Blank;
  assign w_nibble = r_snap_dig[r_idx];

  hex_to_segs u_dec (
    .i_nibble (w_nibble),
    .o_segs   (w_dec)
  );

  always_comb begin
    w_an   = '0;
    w_segs = SEGS_OFF;
    w_dp   = 1'b0;
    if (w_lit) begin
      w_an   = N_DIGITS'(1) << r_idx;
      w_segs = w_dec;
      w_dp   = r_snap_dp[r_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      for (int i = 0; i < N_DIGITS; i++) begin
        r_snap_dig[i] <= Digits[4*i +: 4];
      end
      r_snap_dp <= DpIn;
      r_snap_en <= DigitEn;
      r_an   <= AN_INV;
      r_segs <= SEG_INV;
      r_dp   <= DP_INV;
      r_tick <= 1'b0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
      if (w_slot_end) begin
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      end
      if (w_frame_end) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          r_snap_dig[i] <= Digits[4*i +: 4];
        end
        r_snap_dp <= DpIn;
        r_snap_en <= DigitEn;
      end
      r_an   <= w_an ^ AN_INV;
      r_segs <= w_segs ^ SEG_INV;
      r_dp   <= w_dp ^ DP_INV;
      r_tick <= w_frame_end;
    end
  end

  assign Segs     = r_segs;
  assign Dp       = r_dp;
  assign An       = r_an;
  assign ScanTick = r_tick;

endmodule

// File: doc/seven_segs_scan.md
Name: seven_segs_scan

Overview:
- Parametrised multiplexed driver for N common-anode/cathode seven-segment digits; successor to the single-digit combinational decoder wrapper.
- Time-multiplexes one shared segment bus across N digit enables.
- Adds frame-coherent input snapshot, per-digit enable, decimal points, global blank, anti-ghosting dead time and configurable output polarity.
- Sits between CPU/debug register outputs and board display pins.

Parameters:
N_DIGITS, 4, number of digits (1..8).
REFRESH_DIV, 50000, clock cycles per digit slot (>=2).
DEAD_CYCLES, 500, cycles at the start of each slot with all anodes off (0 <= DEAD_CYCLES < REFRESH_DIV).
SEG_ACTIVE_LOW, 0, 1 = Segs/Dp driven low for "lit".
AN_ACTIVE_LOW, 0, 1 = An driven low for "selected".

Ports:
Clk  input  1  system clock.
Rst  input  1  synchronous, active-high reset.
Digits  input  4*N_DIGITS  hex nibble per digit; digit i = Digits[4i+3:4i].
DpIn  input  N_DIGITS  decimal point per digit, 1 = lit.
DigitEn  input  N_DIGITS  per-digit enable; 0 = digit dark.
Blank  input  1  global blank, live (not snapshotted).
Segs  output  7  {g,f,e,d,c,b,a}, registered.
Dp  output  1  decimal point, registered.
An  output  N_DIGITS  digit select, one-hot or all-off, registered.
ScanTick  output  1  one-cycle pulse at frame start.

Behaviour:
- Decided: one clock Clk; reset Rst is synchronous and active-high.
- Reset (Rst=1 at an edge):
  - Cnt=0, Idx=0.
  - Snapshot regs load live Digits/DpIn/DigitEn.
  - An = all inactive; Segs and Dp = unlit; ScanTick=0.
  - All values are at the configured polarity.
- Prescaler Cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - When Cnt==REFRESH_DIV-1, Idx advances: Idx+1, or 0 when Idx==N_DIGITS-1.
- Snapshot reload happens on the edge where Cnt==REFRESH_DIV-1 and Idx==N_DIGITS-1 (frame wrap).
  - Digits changing mid-frame never alter the frame being shown.
- Lit condition: computed each cycle from the current Cnt, Idx, snapshot and Blank.
  - lit = (Cnt >= DEAD_CYCLES) && SnapEn[Idx] && !Blank.
  - If lit: An = one-hot bit Idx; Segs = decode(SnapDigit[Idx]); Dp = SnapDp[Idx].
  - If not lit: An all off, Segs=0, Dp=0.
  - Result is registered, so outputs lag Cnt/Idx by 1 cycle. Blank takes effect 1 cycle after it is sampled.
- Polarity: inversion for SEG_ACTIVE_LOW / AN_ACTIVE_LOW is applied after the logic above, at the output register input.
- Decode, active-high, hex:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- ScanTick: registered; high for exactly the 1 cycle after Idx wraps N_DIGITS-1 -> 0. It is not asserted on reset release.
- Frame period = N_DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-DEAD_CYCLES cycles per frame.
- N_DIGITS=1: Idx stays 0; snapshot reloads every REFRESH_DIV cycles; ScanTick pulses every slot.
- Reset mid-slot: takes effect at the next edge; scan restarts at digit 0 with a dead interval.
- Illegal parameters (DEAD_CYCLES >= REFRESH_DIV, REFRESH_DIV < 2, N_DIGITS out of 1..8) are rejected by elaboration-time check.
- Cnt width = clog2(REFRESH_DIV); Idx width = max(1, clog2(N_DIGITS)).

Decomposition:
- Shared package seven_segs_pkg:
  - SEG_* 7-bit pattern constants for 0..F.
  - SEGS_OFF constant.
  - Segment-order typedef (7-bit {g..a}).
- Sub-module hex_to_segs: combinational, 4-bit nibble -> 7-bit active-high pattern. It is reused by any single-digit display.
- seven_segs_scan instantiates one hex_to_segs on the muxed snapshot nibble.

Test Plan:
1. Bench parameters: N=4, REFRESH_DIV=4, DEAD=1, active-high polarity. Release Rst with Digits=16'h1234, DigitEn=4'hF, DpIn=0.
   -> An pattern, period 16 cycles: 0000 x1, 0001 x3, 0000 x1, 0010 x3, 0000 x1, 0100 x3, 0000 x1, 1000 x3.
   -> Segs during each lit slot: 66 on An=0001, 4F on 0010, 5B on 0100, 06 on 1000.
2. Change Digits to 16'hABCD in the middle of the digit-1 slot.
   -> Rest of that frame still shows 1234 patterns.
   -> Next frame shows 5E/39/7C/77.
   -> ScanTick is high 1 cycle at each frame start.
3. DigitEn=4'b0101, DpIn=4'b0001.
   -> An never shows 0010 or 1000; those slots are all-off.
   -> Dp=1 only while An=0001.
4. Assert Blank for 3 cycles mid-slot.
   -> An=0000, Segs=00 starting 1 cycle after Blank is sampled, for 3 cycles; display resumes 1 cycle after Blank falls.
   -> Cnt/Idx sequence is unaffected.
5. SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, Digits nibble 8.
   -> Segs=00, An has a single 0 bit when lit, all-ones during reset and dead time.
6. Assert Rst while the digit-2 slot is lit.
   -> Next cycle all outputs are unlit.
   -> After release, the scan restarts with a dead cycle then digit 0, using the inputs captured during reset.
